// File: rtl/sr_iter.sv
// Iterative right shifter: shifts a captured operand right one bit per clock,
// logical or arithmetic, with a start/busy/done handshake.
module sr_iter #(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [SHW-1:0] shamt,
  input  logic           arith,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   C
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [N-1:0]   w_q, w_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic           sgn_q, sgn_d;
  logic [N-1:0]   c_q, c_d;
  logic [N-1:0]   shifted;

  // Sign fill comes from the captured sign, not the live A input.
  assign shifted = {(sgn_q ? w_q[N-1] : 1'b0), w_q[N-1:1]};

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    c_d     = c_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          w_d   = A;
          cnt_d = shamt;
          sgn_d = arith;
          if (shamt == '0) begin
            c_d     = A;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        w_d   = shifted;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          c_d     = shifted;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      c_q     <= c_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign C    = c_q;

endmodule

// File: tb/tb_sr_iter.sv
// Self-checking bench for sr_iter: directed table, handshake corner cases,
// asynchronous reset abort and randomized operations against a shift model.
module tb_sr_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] A;
  logic [4:0]  shamt;
  logic        arith;
  logic        busy;
  logic        done;
  logic [31:0] C;

  int compared;
  int mismatched;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  s;
    logic        ar;
    logic [31:0] expC;
    int          expBusy;
    int          expLat;
  } vec_t;

  vec_t vecs[8];

  sr_iter #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .shamt (shamt),
    .arith (arith),
    .busy  (busy),
    .done  (done),
    .C     (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] refShift(input logic [31:0] a, input int s, input logic ar);
    if (ar) return 32'($signed(a) >>> s);
    return a >> s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Launches one operation from IDLE, drops start after E0 and waits for done.
  task automatic applyStimulus(input logic [31:0] a, input logic [4:0] s, input logic ar,
                               input logic [31:0] prevC, output logic [31:0] c,
                               output int busyCnt, output int lat, output bit holdOk);
    @(negedge clk);
    A = a; shamt = s; arith = ar; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busyCnt = 0; lat = -1; holdOk = 1'b1; c = '0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) @(negedge clk);
      if (done) begin
        lat = k;
        c = C;
        break;
      end
      if (busy) busyCnt++;
      if (C !== prevC) holdOk = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] c, prevExp, expC;
    int busyCnt, lat;
    bit holdOk, sawDone;
    logic [4:0] rs;
    logic [31:0] ra;
    logic rar;

    compared = 0;
    mismatched = 0;
    start = 1'b0; A = '0; shamt = '0; arith = 1'b0;
    rst_n = 1'b0;

    vecs[0] = '{32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000, 4,  4};
    vecs[1] = '{32'hF000_0000, 5'd4,  1'b1, 32'hFF00_0000, 4,  4};
    vecs[2] = '{32'h7000_0000, 5'd4,  1'b1, 32'h0700_0000, 4,  4};
    vecs[3] = '{32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, 0,  0};
    vecs[4] = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 31, 31};
    vecs[5] = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 31, 31};
    vecs[6] = '{32'h1234_5678, 5'd2,  1'b0, 32'h048D_159E, 2,  2};
    vecs[7] = '{32'h8000_0001, 5'd1,  1'b1, 32'hC000_0000, 1,  1};

    #12;
    checkOutput("resetBusyDone", {30'd0, busy, done}, 32'd0);
    checkOutput("resetC", C, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    prevExp = 32'd0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].s, vecs[i].ar, prevExp, c, busyCnt, lat, holdOk);
      checkOutput($sformatf("vec%0d C", i), c, vecs[i].expC);
      checkOutput($sformatf("vec%0d busyCycles", i), 32'(busyCnt), 32'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
      checkOutput($sformatf("vec%0d holdC", i), {31'd0, holdOk}, 32'd1);
      @(negedge clk);
      checkOutput($sformatf("vec%0d doneOnce", i), {30'd0, busy, done}, 32'd0);
      checkOutput($sformatf("vec%0d heldAfter", i), C, vecs[i].expC);
      prevExp = vecs[i].expC;
    end

    // Start pulsed again mid-SHIFT with a different operand must be ignored.
    @(negedge clk);
    A = 32'h0000_F000; shamt = 5'd8; arith = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1; c = '0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 2) begin
        start = 1'b1; A = 32'hFFFF_FFFF; shamt = 5'd0; arith = 1'b1;
      end
      if (k == 4) start = 1'b0;
      if (done) begin
        lat = k;
        c = C;
        break;
      end
    end
    checkOutput("midShift C", c, 32'h0000_00F0);
    checkOutput("midShift latency", 32'(lat), 32'd8);
    prevExp = 32'h0000_00F0;
    @(negedge clk);

    // Start held through DONE launches the next operation with no IDLE cycle.
    @(negedge clk);
    A = 32'h0000_0100; shamt = 5'd4; arith = 1'b0; start = 1'b1;
    @(negedge clk);
    lat = -1; c = '0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) @(negedge clk);
      if (done) begin
        lat = k;
        c = C;
        A = 32'h8000_0000; shamt = 5'd3; arith = 1'b1;
        break;
      end
    end
    checkOutput("b2b first C", c, 32'h0000_0010);
    checkOutput("b2b first latency", 32'(lat), 32'd4);
    @(negedge clk);
    checkOutput("b2b relaunch busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    lat = -1; c = '0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) @(negedge clk);
      if (done) begin
        lat = k;
        c = C;
        break;
      end
    end
    checkOutput("b2b second C", c, 32'hF000_0000);
    checkOutput("b2b second latency", 32'(lat), 32'd3);
    prevExp = 32'hF000_0000;
    @(negedge clk);

    // Asynchronous reset during SHIFT aborts the operation.
    @(negedge clk);
    A = 32'hABCD_0000; shamt = 5'd8; arith = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("preReset busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort busyDone", {30'd0, busy, done}, 32'd0);
    checkOutput("abort C", C, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sawDone = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) sawDone = 1'b1;
    end
    checkOutput("abort noDone", {31'd0, sawDone}, 32'd0);
    applyStimulus(32'hABCD_0000, 5'd8, 1'b0, 32'd0, c, busyCnt, lat, holdOk);
    checkOutput("fresh C", c, 32'h00AB_CD00);
    checkOutput("fresh latency", 32'(lat), 32'd8);
    checkOutput("fresh holdC", {31'd0, holdOk}, 32'd1);
    prevExp = 32'h00AB_CD00;

    for (int i = 0; i < 40; i++) begin
      ra  = $urandom;
      rs  = 5'($urandom_range(0, 31));
      rar = 1'($urandom_range(0, 1));
      expC = refShift(ra, int'(rs), rar);
      applyStimulus(ra, rs, rar, prevExp, c, busyCnt, lat, holdOk);
      checkOutput($sformatf("rnd%0d C a=%08h s=%0d ar=%0d", i, ra, rs, rar), c, expC);
      checkOutput($sformatf("rnd%0d busyCycles", i), 32'(busyCnt), 32'(rs));
      checkOutput($sformatf("rnd%0d latency", i), 32'(lat), 32'(rs));
      checkOutput($sformatf("rnd%0d holdC", i), {31'd0, holdOk}, 32'd1);
      prevExp = expC;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
